// File: rtl/hs_cmd_issuer.sv
// hs_cmd_issuer: command word FIFO feeding a four-phase req/ack handshake
// initiator. Words are taken from a valid/ready stream and queued. They are
// then issued one at a time to a downstream run/done adapter. The block also
// counts completed handshakes and raises a sticky flag when a handshake stalls.
module hs_cmd_issuer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  output logic                     req,
  input  logic                     ack,
  output logic [31:0]              data_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     timeout_err,
  input  logic                     clr_err,
  output logic [31:0]              issued_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  // The wait counter holds values up to TIMEOUT and then stops, so the flag
  // sets only once per stall and clr_err stays effective during a long stall.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] TO_MAX  = CW'((TIMEOUT > 0) ? TIMEOUT : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REL  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic          req_reg, req_next;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] wait_cnt_reg;
  logic          err_reg;
  logic [31:0]   issued_reg;
  logic          full, empty, push, pop, timeout_hit;

  // Occupancy is the pointer difference. The extra pointer bit tells full from empty.
  assign level    = wr_ptr_reg - rd_ptr_reg;
  assign full     = (level == PW'(DEPTH));
  assign empty    = (level == '0);
  // Full blocks the push even when a pop happens in the same cycle.
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state_reg == S_REQ) && ack;

  // The head stays put while req is high, because the pop happens only on leaving S_REQ.
  assign data_out    = empty ? 32'd0 : mem[rd_ptr_reg[AW-1:0]];
  assign req         = req_reg;
  assign busy        = (state_reg != S_IDLE) || !empty;
  assign timeout_err = err_reg;
  assign issued_cnt  = issued_reg;

  assign timeout_hit = TO_EN && (state_reg == S_REQ) && !ack &&
                       (wait_cnt_reg == TO_LAST);

  // Storage array: write-only on push, no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= in_data;
    end
  end

  // FIFO pointers: reset flushes the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Handshake state and registered req. Reset drops req without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      req_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
    end
  end

  // Next-state logic. req is high exactly while the FSM is in S_REQ.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (!empty && !ack) state_next = S_REQ;
      S_REQ:   if (ack)            state_next = S_REL;
      S_REL:   if (!ack)           state_next = S_IDLE;
      default:                     state_next = S_IDLE;
    endcase
    req_next = (state_next == S_REQ);
  end

  // Stall counter: zero outside S_REQ, so each new request starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
    end else if (state_reg != S_REQ) begin
      wait_cnt_reg <= '0;
    end else if (!ack && (wait_cnt_reg != TO_MAX)) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  // Sticky stall flag. Setting takes priority over clr_err. The handshake itself is never aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (timeout_hit) begin
      err_reg <= 1'b1;
    end else if (clr_err) begin
      err_reg <= 1'b0;
    end
  end

  // Completed-command counter. It wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_reg <= 32'd0;
    end else if (pop) begin
      issued_reg <= issued_reg + 32'd1;
    end
  end

endmodule
